debug_cmd_ctrl: RTL and testbench



---
 rtl/debug_cmd_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_debug_cmd_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debug_cmd_ctrl                                                |
// | Brief    : UART byte-command controller: program load, run/step control  |
// |            and register/pipeline-latch dump for the pipelined MIPS core.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module debug_cmd_ctrl #(
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_REGISTERS   = 32,
  parameter int IF_ID_WORDS     = 1,
  parameter int ID_EX_WORDS     = 5,
  parameter int EX_MEM_WORDS    = 3,
  parameter int MEM_WB_WORDS    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_data,
  output logic                  o_stall,
  output logic                  o_cpu_rst,
  input  logic                  i_halt,
  output logic [2:0]            o_dump_sel,
  output logic [7:0]            o_dump_idx,
  input  logic [31:0]           i_dump_word
);

  localparam logic [2:0] c_idle       = 3'd0;
  localparam logic [2:0] c_load_cnt   = 3'd1;
  localparam logic [2:0] c_load_byte  = 3'd2;
  localparam logic [2:0] c_dump_fetch = 3'd3;
  localparam logic [2:0] c_dump_send  = 3'd4;
  localparam logic [2:0] c_dump_wait  = 3'd5;

  localparam logic [7:0] c_cmd_load   = 8'h07;
  localparam logic [7:0] c_cmd_cont   = 8'h08;
  localparam logic [7:0] c_cmd_stepm  = 8'h09;
  localparam logic [7:0] c_cmd_step   = 8'h0A;
  localparam logic [7:0] c_cmd_start  = 8'h0D;
  localparam logic [7:0] c_cmd_status = 8'h11;

  localparam logic [8:0] c_max_cnt = 9'(MAX_INSTRUCTION);

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic                  r_running;
  logic                  r_step_mode;
  logic                  r_step_pulse;
  logic                  r_halted;
  logic                  r_cpu_rst;
  logic [1:0]            r_byte_cnt;
  logic [7:0]            r_word_cnt;
  logic [7:0]            r_word_total;
  logic [23:0]           r_word_buf;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_data;
  logic [2:0]            r_dump_sel;
  logic [7:0]            r_dump_idx;
  logic [31:0]           r_dump_word;
  logic                  r_status_xfer;
  logic                  r_final;

  logic                  w_dump_cmd;
  logic                  w_cnt_ok;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_last_load_word;

  function automatic logic [7:0] src_words(input logic [2:0] sel);
    case (sel)
      3'd0:    src_words = 8'(NUM_REGISTERS);
      3'd1:    src_words = 8'(IF_ID_WORDS);
      3'd2:    src_words = 8'(ID_EX_WORDS);
      3'd3:    src_words = 8'(EX_MEM_WORDS);
      default: src_words = 8'(MEM_WB_WORDS);
    endcase
  endfunction

  assign w_dump_cmd       = (i_rx_data >= 8'h01) && (i_rx_data <= 8'h05);
  assign w_cnt_ok         = (i_rx_data != 8'd0) && ({1'b0, i_rx_data} <= c_max_cnt);
  assign w_last_byte      = (r_byte_cnt == 2'd3);
  assign w_last_word      = (r_dump_idx == src_words(r_dump_sel) - 8'd1);
  assign w_last_load_word = (r_word_cnt == r_word_total - 8'd1);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_idle;
    else          r_state <= w_state_next;
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (i_rx_valid) begin
          if (w_dump_cmd)                     w_state_next = c_dump_fetch;
          else if (i_rx_data == c_cmd_load)   w_state_next = c_load_cnt;
          else if (i_rx_data == c_cmd_status) w_state_next = c_dump_send;
        end
      end
      c_load_cnt:   if (i_rx_valid) w_state_next = w_cnt_ok ? c_load_byte : c_idle;
      c_load_byte:  if (i_rx_valid && w_last_byte && w_last_load_word) w_state_next = c_idle;
      c_dump_fetch: w_state_next = c_dump_send;
      c_dump_send:  w_state_next = c_dump_wait;
      c_dump_wait:  if (i_tx_done) w_state_next = r_final ? c_idle : c_dump_send;
      default:      w_state_next = c_idle;
    endcase
  end

  // output logic
  always_comb begin
    o_tx_start = (r_state == c_dump_send);
    o_tx_data  = r_dump_word[7:0];
    case (r_byte_cnt)
      2'd1:    o_tx_data = r_dump_word[15:8];
      2'd2:    o_tx_data = r_dump_word[23:16];
      2'd3:    o_tx_data = r_dump_word[31:24];
      default: o_tx_data = r_dump_word[7:0];
    endcase
    // i_halt is folded in directly so the core freezes in the cycle halt rises
    o_stall = !(r_running && !i_halt && (!r_step_mode || r_step_pulse));
  end

  assign o_imem_we   = r_imem_we;
  assign o_imem_addr = r_imem_addr;
  assign o_imem_data = r_imem_data;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_dump_sel  = r_dump_sel;
  assign o_dump_idx  = r_dump_idx;

  // datapath and execution-control flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_running     <= 1'b0;
      r_step_mode   <= 1'b0;
      r_step_pulse  <= 1'b0;
      r_halted      <= 1'b0;
      r_cpu_rst     <= 1'b1;
      r_byte_cnt    <= 2'd0;
      r_word_cnt    <= 8'd0;
      r_word_total  <= 8'd0;
      r_word_buf    <= 24'd0;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_data   <= 32'd0;
      r_dump_sel    <= 3'd0;
      r_dump_idx    <= 8'd0;
      r_dump_word   <= 32'd0;
      r_status_xfer <= 1'b0;
      r_final       <= 1'b0;
    end else begin
      r_imem_we    <= 1'b0;
      r_step_pulse <= 1'b0;
      case (r_state)
        c_idle: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
                r_dump_sel    <= 3'(i_rx_data - 8'd1);
                r_dump_idx    <= 8'd0;
                r_status_xfer <= 1'b0;
              end
              c_cmd_status: begin
                r_dump_word   <= {29'd0, i_halt, r_step_mode, r_running};
                r_byte_cnt    <= 2'd0;
                r_status_xfer <= 1'b1;
              end
              c_cmd_cont:  r_step_mode <= 1'b0;
              c_cmd_stepm: r_step_mode <= 1'b1;
              c_cmd_step:  if (r_step_mode && r_running && !i_halt) r_step_pulse <= 1'b1;
              c_cmd_start: begin
                r_cpu_rst <= 1'b0;
                if (!r_halted) r_running <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        c_load_cnt: begin
          if (i_rx_valid && w_cnt_ok) begin
            r_cpu_rst    <= 1'b1;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= 8'd0;
            r_word_total <= i_rx_data;
          end
        end
        c_load_byte: begin
          if (i_rx_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word_buf[7:0]   <= i_rx_data;
              2'd1: r_word_buf[15:8]  <= i_rx_data;
              2'd2: r_word_buf[23:16] <= i_rx_data;
              default: begin
                r_imem_we   <= 1'b1;
                r_imem_addr <= ADDR_WIDTH'(r_word_cnt);
                r_imem_data <= {i_rx_data, r_word_buf};
                r_word_cnt  <= r_word_cnt + 8'd1;
              end
            endcase
          end
        end
        c_dump_fetch: begin
          r_dump_word <= i_dump_word;
          r_byte_cnt  <= 2'd0;
        end
        c_dump_send: begin
          r_final <= r_status_xfer || (w_last_byte && w_last_word);
          // advance the index while the last byte is in flight so the next
          // word is already addressed when i_tx_done arrives
          if (w_last_byte && !w_last_word && !r_status_xfer) r_dump_idx <= r_dump_idx + 8'd1;
        end
        c_dump_wait: begin
          if (i_tx_done) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) r_dump_word <= i_dump_word;
          end
        end
        default: ;
      endcase
      if (r_running && i_halt) begin
        r_running <= 1'b0;
        r_halted  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_debug_cmd_ctrl                                             |
// | Brief    : Randomized self-checking bench for debug_cmd_ctrl.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_debug_cmd_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        cpu_rst;
  logic        halt = 1'b0;
  logic [2:0]  dump_sel;
  logic [7:0]  dump_idx;
  logic [31:0] dump_word;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // reference model of the execution state
  bit m_running = 1'b0;
  bit m_step = 1'b0;
  bit m_halted = 1'b0;
  bit m_cpu_rst = 1'b1;
  int m_step_at = -1;
  wr_t        q_wr[$];
  logic [7:0] q_tx[$];
  logic [7:0] tx_log[$];
  int first_start_cyc = -1;
  int last_done_cyc = 0;
  bit in_flight = 1'b0;
  int tx_delay = 0;
  int stall_low_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;
  logic [31:0] ld_words[64];
  int wtab[5] = '{32, 1, 5, 3, 3};

  debug_cmd_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_done   (tx_done),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_stall     (stall),
    .o_cpu_rst   (cpu_rst),
    .i_halt      (halt),
    .o_dump_sel  (dump_sel),
    .o_dump_idx  (dump_idx),
    .i_dump_word (dump_word)
  );

  function automatic logic [31:0] src_word(input logic [2:0] sel, input logic [7:0] idx);
    return {idx, 8'hAB, 8'hCD, 5'b11100, sel};
  endfunction

  assign dump_word = src_word(dump_sel, dump_idx);

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // per-cycle comparison of the DUT against the model
  initial begin : compare
    logic exp_stall;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_stall = !(m_running && !halt && (!m_step || m_step_at == cyc));
        chk("stall", stall, exp_stall);
        chk("cpu_rst", cpu_rst, m_cpu_rst);
        if (!stall) stall_low_cnt++;
        if (imem_we) begin
          wr_cnt++;
          last_addr = imem_addr;
          last_data = imem_data;
          if (q_wr.size() == 0) chk("imem_we_unexpected", 1, 0);
          else begin
            w = q_wr.pop_front();
            chk("imem_we_cycle", cyc, w.cyc);
            chk("imem_addr", imem_addr, w.addr);
            chk("imem_data", imem_data, w.data);
          end
        end
        if (tx_start) begin
          chk("tx_start_in_flight", in_flight, 0);
          if (q_tx.size() == 0) chk("tx_start_unexpected", 1, 0);
          else chk("tx_data", tx_data, q_tx.pop_front());
          chk("tx_start_cycle", cyc, (first_start_cyc >= 0) ? first_start_cyc : last_done_cyc + 1);
          first_start_cyc = -1;
          tx_log.push_back(tx_data);
          in_flight = 1'b1;
          tx_delay = $urandom_range(0, 4);
        end
      end
    end
  end

  // transmitter stand-in: i_tx_done a random number of cycles after each start
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_done) begin
      tx_done = 1'b0;
      in_flight = 1'b0;
    end else if (in_flight) begin
      if (tx_delay == 0) begin
        tx_done = 1'b1;
        last_done_cyc = cyc;
      end else tx_delay--;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while ((q_tx.size() != 0 || in_flight || tx_done) && n < 3000) begin
      tick();
      n++;
    end
    chk("dump_timeout", (n < 3000), 1);
  endtask

  task automatic set_halt(input logic v);
    halt = v;
    if (v && m_running) begin
      m_running = 1'b0;
      m_halted = 1'b1;
    end
  endtask

  // one command byte issued from the idle state, with its effect on the model
  task automatic cmd(input logic [7:0] b);
    logic [7:0]  st;
    logic [2:0]  sel;
    logic [31:0] w;
    st = {5'd0, halt, m_step, m_running};
    send(b);
    case (b)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
        sel = 3'(b - 8'd1);
        for (int i = 0; i < wtab[sel]; i++) begin
          w = src_word(sel, 8'(i));
          for (int k = 0; k < 4; k++) q_tx.push_back(w[8*k +: 8]);
        end
        first_start_cyc = cyc + 1;
        wait_tx_drain();
      end
      8'h08: m_step = 1'b0;
      8'h09: m_step = 1'b1;
      8'h0A: if (m_step && m_running && !halt) m_step_at = cyc;
      8'h0D: begin
        m_cpu_rst = 1'b0;
        if (!m_halted) m_running = 1'b1;
      end
      8'h11: begin
        q_tx.push_back(st);
        first_start_cyc = cyc;
        wait_tx_drain();
      end
      default: ;
    endcase
  endtask

  task automatic load(input int n, input bit rnd);
    wr_t e;
    send(8'h07);
    send(8'(n));
    if (n >= 1 && n <= 64) begin
      m_cpu_rst = 1'b1;
      m_running = 1'b0;
      m_halted = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (rnd) ld_words[i] = $urandom;
        for (int k = 0; k < 4; k++) begin
          idle($urandom_range(0, 2));
          send(ld_words[i][8*k +: 8]);
        end
        e.cyc = cyc;
        e.addr = 32'(i);
        e.data = ld_words[i];
        q_wr.push_back(e);
      end
      idle(1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stall"}, stall, 1);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_data"}, imem_data, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_dump_sel"}, dump_sel, 0);
    chk({tag, "_dump_idx"}, dump_idx, 0);
  endtask

  initial begin : main
    int base;
    int r;
    wr_t e;
    #12;
    check_reset_vals("reset");
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // ignored bytes and a step with nothing running
    for (int i = 0; i < 4; i++) cmd(8'($urandom_range(8'h40, 8'hFF)));
    cmd(8'h0A);

    // program load of three known words
    ld_words[0] = 32'h3C010003;
    ld_words[1] = 32'h3C020001;
    ld_words[2] = 32'h3C030009;
    base = wr_cnt;
    load(3, 1'b0);
    chk("load3_count", wr_cnt - base, 3);
    chk("load3_last_addr", last_addr, 32'd2);
    chk("load3_last_data", last_data, 32'h3C030009);
    chk("load3_cpu_rst", cpu_rst, 1);

    // out-of-range counts write nothing; following command still decodes
    base = wr_cnt;
    load(0, 1'b1);
    load(8'h41, 1'b1);
    cmd(8'h08);
    idle(3);
    chk("bad_count_writes", wr_cnt - base, 0);

    // step mode: one early step is ignored, then three isolated steps
    cmd(8'h09);
    base = stall_low_cnt;
    cmd(8'h0A);
    idle(2);
    cmd(8'h0D);
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(1, 4));
      cmd(8'h0A);
    end
    idle(3);
    chk("step_low_cycles", stall_low_cnt - base, 3);

    // ID/EX dump: 20 bytes, least-significant byte first
    base = tx_log.size();
    cmd(8'h03);
    chk("dump3_bytes", tx_log.size() - base, 20);
    chk("dump3_first", tx_log[base], 8'hE2);
    chk("dump3_byte7", tx_log[base + 7], 8'h01);
    chk("dump3_last", tx_log[base + 19], 8'h04);

    // continuous run, then halt
    cmd(8'h08);
    idle($urandom_range(10, 30));
    set_halt(1'b1);
    idle(3);
    cmd(8'h0A);
    cmd(8'h0D);
    idle(2);
    cmd(8'h11);
    chk("status_after_halt", tx_log[tx_log.size() - 1], 8'h04);
    set_halt(1'b0);
    idle(3);
    chk("halt_sticky_stall", stall, 1);
    load(1, 1'b1);
    cmd(8'h0D);
    idle(2);

    // randomized command mix
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: cmd(8'($urandom_range(1, 5)));
        1: cmd(8'h11);
        2: cmd(8'h08);
        3: cmd(8'h09);
        4, 5: cmd(8'h0A);
        6: cmd(8'h0D);
        7: cmd(8'($urandom_range(8'h40, 8'hFF)));
        8: load($urandom_range(1, 4), 1'b1);
        default: idle($urandom_range(1, 6));
      endcase
      idle($urandom_range(0, 3));
    end

    // reset in the middle of a two-word load, then a fresh one-word load
    send(8'h07);
    send(8'h02);
    m_cpu_rst = 1'b1;
    m_running = 1'b0;
    m_halted = 1'b0;
    ld_words[0] = $urandom;
    ld_words[1] = $urandom;
    for (int k = 0; k < 4; k++) send(ld_words[0][8*k +: 8]);
    e.cyc = cyc;
    e.addr = 32'd0;
    e.data = ld_words[0];
    q_wr.push_back(e);
    idle(1);
    send(ld_words[1][7:0]);
    send(ld_words[1][15:8]);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    chk("abort_pending_writes", q_wr.size(), 0);
    m_running = 1'b0;
    m_step = 1'b0;
    m_halted = 1'b0;
    m_cpu_rst = 1'b1;
    idle(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    base = wr_cnt;
    ld_words[0] = $urandom;
    load(1, 1'b0);
    idle(3);
    chk("reload_count", wr_cnt - base, 1);
    chk("reload_addr", last_addr, 32'd0);
    chk("reload_data", last_data, ld_words[0]);

    cmd(8'h0D);
    idle(5);
    chk("final_wr_queue", q_wr.size(), 0);
    chk("final_tx_queue", q_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
